drive_gain_stage: RTL

DRIVE_GAIN_STAGE -- requirements
Module: drive_gain_stage

---
 rtl/drive_pkg.sv | 18 +
 rtl/gain_ramp.sv | 67 ++++++
 rtl/drive_gain_stage.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/drive_pkg.sv
// -----------------------------------------------------------------------------
// drive_pkg
// Shared constants for the drive chain (gain stage and downstream clamp stage).
//   SAMPLE_W           : width of signed fixed-point audio/drive samples
//   DEF_BITS_PER_LEVEL : default number of fraction bits in samples and gains
//   DEF_GAIN_W         : default unsigned gain width
//   ONE                : unity level for the default fraction width
//   CLIP_W             : width of the saturating clip counter
// -----------------------------------------------------------------------------
package drive_pkg;

    localparam int SAMPLE_W           = 32;
    localparam int DEF_BITS_PER_LEVEL = 12;
    localparam int DEF_GAIN_W         = 16;
    localparam int ONE                = 1 << DEF_BITS_PER_LEVEL;
    localparam int CLIP_W             = 16;

endpackage : drive_pkg

// File: rtl/gain_ramp.sv
// -----------------------------------------------------------------------------
// gain_ramp
// Slew-limited gain register. On every enabled step the current gain moves
// toward the target by at most RAMP_STEP and never overshoots it.
//   clk     : rising-edge clock
//   rst     : synchronous active-high reset, current gain returns to 0
//   step_en : advance the ramp by one step this cycle
//   target  : requested gain
//   current : present gain (value before this cycle's step)
//   ramping : high while current differs from target
// -----------------------------------------------------------------------------
module gain_ramp
    import drive_pkg::*;
#(
    parameter int GAIN_W    = DEF_GAIN_W,
    parameter int RAMP_STEP = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step_en,
    input  logic [GAIN_W-1:0] target,
    output logic [GAIN_W-1:0] current,
    output logic              ramping
);

    localparam logic [GAIN_W-1:0] STEP = GAIN_W'(RAMP_STEP);

    logic [GAIN_W-1:0] current_r;
    logic [GAIN_W-1:0] next_s;
    logic [GAIN_W-1:0] up_gap_s;
    logic [GAIN_W-1:0] down_gap_s;

    // Next gain: one bounded step toward target, snapping onto it when close.
    always_comb begin
        next_s     = current_r;
        up_gap_s   = target - current_r;
        down_gap_s = current_r - target;
        if (target > current_r) begin
            if (up_gap_s > STEP) begin
                next_s = current_r + STEP;
            end else begin
                next_s = target;
            end
        end else if (target < current_r) begin
            if (down_gap_s > STEP) begin
                next_s = current_r - STEP;
            end else begin
                next_s = target;
            end
        end else begin
            next_s = current_r;
        end
    end

    // Gain register: starts muted after reset, moves only on enabled steps.
    always_ff @(posedge clk) begin
        if (rst) begin
            current_r <= {GAIN_W{1'b0}};
        end else if (step_en) begin
            current_r <= next_s;
        end
    end

    assign current = current_r;
    assign ramping = (current_r != target);

endmodule : gain_ramp

// File: rtl/drive_gain_stage.sv
// -----------------------------------------------------------------------------
// drive_gain_stage
// Two-stage valid/ready gain pipeline. Stage 1 multiplies the accepted sample
// by the ramped gain (or unity in bypass); stage 2 rescales by the fraction
// bits with floor rounding and saturates to +/-SAT_LIMIT.
//   clk, rst     : rising-edge clock, synchronous active-high reset
//   in_sample    : signed fixed-point input sample
//   in_valid     : in_sample valid
//   in_ready     : stage accepts a sample this cycle
//   gain_target  : requested gain (unity = 1 << BITS_PER_LEVEL)
//   bypass       : use unity gain for the sample being accepted
//   out_sample   : scaled, saturated sample
//   out_valid    : out_sample valid
//   out_ready    : downstream accepts out_sample
//   gain_current : gain the next accepted sample uses
//   ramping      : gain_current has not yet reached gain_target
//   clip_count   : saturating count of clipped output samples
// -----------------------------------------------------------------------------
module drive_gain_stage
    import drive_pkg::*;
#(
    parameter int BITS_PER_LEVEL = DEF_BITS_PER_LEVEL,
    parameter int GAIN_W         = DEF_GAIN_W,
    parameter int RAMP_STEP      = 16,
    parameter int SAT_LIMIT      = 65536
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [SAMPLE_W-1:0] in_sample,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic        [GAIN_W-1:0]   gain_target,
    input  logic                       bypass,
    output logic signed [SAMPLE_W-1:0] out_sample,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic        [GAIN_W-1:0]   gain_current,
    output logic                       ramping,
    output logic        [CLIP_W-1:0]   clip_count
);

    localparam int                        PROD_W    = SAMPLE_W + GAIN_W + 1;
    localparam logic        [GAIN_W:0]    UNITY     = {{GAIN_W{1'b0}}, 1'b1} << BITS_PER_LEVEL;
    localparam logic signed [PROD_W-1:0]  SAT_POS   = PROD_W'(SAT_LIMIT);
    localparam logic signed [PROD_W-1:0]  SAT_NEG   = -SAT_POS;
    localparam logic        [CLIP_W-1:0]  CLIP_MAX  = {CLIP_W{1'b1}};

    logic                       adv_s;
    logic                       accept_s;
    logic        [GAIN_W-1:0]   gain_cur_s;
    logic        [GAIN_W:0]     gain_sel_s;
    logic signed [PROD_W-1:0]   sample_ext_s;
    logic signed [PROD_W-1:0]   gain_ext_s;
    logic signed [PROD_W-1:0]   prod_s;
    logic signed [PROD_W-1:0]   shifted_s;
    logic signed [SAMPLE_W-1:0] sat_s;
    logic                       clip_s;

    logic                       s1_valid_r;
    logic signed [PROD_W-1:0]   s1_prod_r;
    logic                       out_valid_r;
    logic signed [SAMPLE_W-1:0] out_sample_r;
    logic        [CLIP_W-1:0]   clip_count_r;

    // The whole pipeline moves together; it only holds while the output is blocked.
    assign adv_s    = !out_valid_r || out_ready;
    assign accept_s = in_valid && adv_s;
    assign in_ready = adv_s;

    gain_ramp #(
        .GAIN_W    (GAIN_W),
        .RAMP_STEP (RAMP_STEP)
    ) u_gain_ramp (
        .clk     (clk),
        .rst     (rst),
        .step_en (accept_s),
        .target  (gain_target),
        .current (gain_cur_s),
        .ramping (ramping)
    );

    // Gain selection and full-precision signed product; the gain is zero-extended
    // so large unsigned gains are never read as negative.
    always_comb begin
        if (bypass) begin
            gain_sel_s = UNITY;
        end else begin
            gain_sel_s = {1'b0, gain_cur_s};
        end
        sample_ext_s = {{(PROD_W-SAMPLE_W){in_sample[SAMPLE_W-1]}}, in_sample};
        gain_ext_s   = {{(PROD_W-GAIN_W-1){1'b0}}, gain_sel_s};
        prod_s       = sample_ext_s * gain_ext_s;
    end

    // Rescale (arithmetic shift gives floor rounding) and saturate.
    always_comb begin
        shifted_s = s1_prod_r >>> BITS_PER_LEVEL;
        if (shifted_s > SAT_POS) begin
            sat_s  = SAT_POS[SAMPLE_W-1:0];
            clip_s = 1'b1;
        end else if (shifted_s < SAT_NEG) begin
            sat_s  = SAT_NEG[SAMPLE_W-1:0];
            clip_s = 1'b1;
        end else begin
            sat_s  = shifted_s[SAMPLE_W-1:0];
            clip_s = 1'b0;
        end
    end

    // Stage 1: capture the product of the accepted sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_prod_r  <= {PROD_W{1'b0}};
        end else if (adv_s) begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_prod_r <= prod_s;
            end
        end
    end

    // Stage 2: registered saturated output; held while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r  <= 1'b0;
            out_sample_r <= {SAMPLE_W{1'b0}};
        end else if (adv_s) begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                out_sample_r <= sat_s;
            end
        end
    end

    // Clip counter: counts saturated samples entering stage 2, sticks at full scale.
    always_ff @(posedge clk) begin
        if (rst) begin
            clip_count_r <= {CLIP_W{1'b0}};
        end else if (adv_s && s1_valid_r && clip_s && (clip_count_r != CLIP_MAX)) begin
            clip_count_r <= clip_count_r + {{(CLIP_W-1){1'b0}}, 1'b1};
        end
    end

    assign out_valid    = out_valid_r;
    assign out_sample   = out_sample_r;
    assign gain_current = gain_cur_s;
    assign clip_count   = clip_count_r;

endmodule : drive_gain_stage
